// File: rtl/acc_sequencer.sv
// acc_sequencer: fetch/decode/execute controller for the accumulator datapath.
// Owns the program counter, instruction register and zero/carry flags, drives
// the ALU opcode/B operand and pulses the W-register load. Jumps and halt are
// resolved here so the datapath carries no branch logic.
module acc_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int ALU_OPS = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  input  logic [11:0]       mem_rdata,
  input  logic              mem_valid,
  output logic [3:0]        alu_inst,
  output logic [7:0]        alu_b,
  input  logic [8:0]        alu_ans,
  output logic              w_load,
  output logic              flag_z,
  output logic              flag_c,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              halted
);

  localparam logic [3:0] OP_JMP    = 4'hB;
  localparam logic [3:0] OP_JZ     = 4'hC;
  localparam logic [3:0] OP_JC     = 4'hD;
  localparam logic [3:0] OP_HLT    = 4'hF;
  localparam logic [4:0] ALU_LIMIT = 5'(ALU_OPS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [11:0]       r_ir;
  logic [ADDR_W-1:0] r_pc;
  logic [3:0]        r_alu_inst;
  logic [7:0]        r_alu_b;
  logic              r_mem_req;
  logic              r_w_load;
  logic              r_flag_z;
  logic              r_flag_c;
  logic              r_busy;
  logic              r_halted;

  logic [3:0]        w_op;
  logic              w_is_alu;
  logic              w_fetch_done;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [ADDR_W-1:0] w_pc_exec;

  assign w_op         = r_ir[11:8];
  assign w_is_alu     = ({1'b0, w_op} < ALU_LIMIT);
  assign w_target     = r_ir[ADDR_W-1:0];
  assign w_pc_inc     = r_pc + ADDR_W'(1);
  // mem_req is high exactly while in FETCH, so a strobe outside FETCH is dropped.
  assign w_fetch_done = (r_state == S_FETCH) && r_mem_req && mem_valid;

  // Program-counter value chosen by the instruction currently in EXEC.
  always_comb begin
    w_pc_exec = w_pc_inc;
    case (w_op)
      OP_JMP:  w_pc_exec = w_target;
      OP_JZ:   w_pc_exec = r_flag_z ? w_target : w_pc_inc;
      OP_JC:   w_pc_exec = r_flag_c ? w_target : w_pc_inc;
      OP_HLT:  w_pc_exec = r_pc;
      default: w_pc_exec = w_pc_inc;
    endcase
  end

  // Next-state logic of the fetch/decode/execute sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start) w_state_nxt = S_FETCH;
      S_FETCH:  if (w_fetch_done) w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = S_EXEC;
      S_EXEC:   w_state_nxt = (w_op == OP_HLT) ? S_HALT : S_FETCH;
      S_HALT:   if (start) w_state_nxt = S_FETCH;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem_req <= 1'b0;
      r_busy    <= 1'b0;
      r_halted  <= 1'b0;
      r_w_load  <= 1'b0;
    end else begin
      r_mem_req <= (w_state_nxt == S_FETCH);
      r_busy    <= (w_state_nxt == S_FETCH) || (w_state_nxt == S_DECODE) ||
                   (w_state_nxt == S_EXEC);
      r_halted  <= (w_state_nxt == S_HALT);
      r_w_load  <= (r_state == S_DECODE) && w_is_alu;
    end
  end

  // Instruction register, ALU operand registers, program counter and flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir       <= '0;
      r_pc       <= '0;
      r_alu_inst <= '0;
      r_alu_b    <= '0;
      r_flag_z   <= 1'b0;
      r_flag_c   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_pc <= '0;
        end
        S_FETCH: begin
          if (w_fetch_done) r_ir <= mem_rdata;
        end
        S_DECODE: begin
          if (w_is_alu) begin
            r_alu_inst <= w_op;
            r_alu_b    <= r_ir[7:0];
          end
        end
        S_EXEC: begin
          r_pc <= w_pc_exec;
          if (w_is_alu) begin
            r_flag_c <= alu_ans[8];
            r_flag_z <= (alu_ans[7:0] == 8'h00);
          end
        end
        S_HALT: begin
          if (start) begin
            r_pc     <= '0;
            r_flag_z <= 1'b0;
            r_flag_c <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_addr = r_pc;
  assign mem_req  = r_mem_req;
  assign alu_inst = r_alu_inst;
  assign alu_b    = r_alu_b;
  assign w_load   = r_w_load;
  assign flag_z   = r_flag_z;
  assign flag_c   = r_flag_c;
  assign pc       = r_pc;
  assign busy     = r_busy;
  assign halted   = r_halted;

endmodule
